// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 Local Binary Pattern engine: raster reads from the gray memory,
// two row line buffers plus a 3x3 window, one registered LBP write per pixel.
module lbp_stream_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  input  logic              mode,
  input  logic [DATA_W-1:0] thr,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish,
  output logic [1:0]        dbg_state
);

  localparam int N     = IMG_W * IMG_H;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] FIRST_OUT = ADDR_W'(IMG_W + 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  // Handshake: a read of gray_addr happens in every cycle with gray_req=1;
  // gray_data is taken at the rising edge that ends that cycle.
  state_t              r_state;
  logic                r_mode;
  logic [DATA_W-1:0]   r_thr;
  logic [COL_W-1:0]    r_rd_col;
  logic [COL_W-1:0]    r_wr_col;
  logic [ROW_W-1:0]    r_wr_row;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_lb0 [IMG_W];
  logic [DATA_W-1:0]   r_lb1 [IMG_W];
  logic [DATA_W-1:0]   r_tl, r_t, r_l, r_c, r_bl, r_b;

  logic [DATA_W-1:0]   w_tr, w_r;
  logic [DATA_W:0]     w_ref;
  logic [7:0]          w_code;
  logic                w_border;
  logic                w_emit;

  function automatic logic ge(input logic [DATA_W-1:0] gp, input logic [DATA_W:0] ref_v);
    return {1'b0, gp} >= ref_v;
  endfunction

  assign dbg_state = r_state;
  assign gray_req  = gray_ready && !reset && (r_state == S_IDLE || r_state == S_READ);

  // The incoming pixel closes the right column of the window centred W+1 pixels back.
  assign w_tr  = r_lb0[r_rd_col];
  assign w_r   = r_lb1[r_rd_col];
  assign w_ref = {1'b0, r_c} + (r_mode ? {1'b0, r_thr} : '0);

  assign w_code = {ge(gray_data, w_ref), ge(r_b, w_ref), ge(r_bl, w_ref), ge(w_r, w_ref),
                   ge(r_l, w_ref), ge(w_tr, w_ref), ge(r_t, w_ref), ge(r_tl, w_ref)};

  assign w_border = (r_wr_row == '0) || (r_wr_row == ROW_LAST) ||
                    (r_wr_col == '0) || (r_wr_col == COL_LAST);

  // Drain results all sit on the last row or last column, so the code is forced to zero.
  assign w_emit = (gray_req && gray_addr >= FIRST_OUT) || (r_state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_thr     <= '0;
      r_rd_col  <= '0;
      r_wr_col  <= '0;
      r_wr_row  <= '0;
      r_wr_addr <= '0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      r_tl <= '0; r_t <= '0; r_l <= '0; r_c <= '0; r_bl <= '0; r_b <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
    end else begin
      lbp_valid <= w_emit;
      if (w_emit) begin
        lbp_addr  <= r_wr_addr;
        lbp_data  <= w_border ? 8'h00 : w_code;
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        if (r_wr_col == COL_LAST) begin
          r_wr_col <= '0;
          r_wr_row <= r_wr_row + ROW_W'(1);
        end else begin
          r_wr_col <= r_wr_col + COL_W'(1);
        end
      end

      if (gray_req) begin
        r_tl <= r_t;  r_l <= r_c;  r_bl <= r_b;
        r_t  <= w_tr; r_c <= w_r;  r_b  <= gray_data;
        r_lb0[r_rd_col] <= w_r;
        r_lb1[r_rd_col] <= gray_data;
        r_rd_col <= (r_rd_col == COL_LAST) ? '0 : r_rd_col + COL_W'(1);
        if (gray_addr != LAST_ADDR) gray_addr <= gray_addr + ADDR_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (gray_ready) begin
            r_state <= S_READ;
            r_mode  <= mode;
            r_thr   <= thr;
          end
        end
        S_READ: begin
          if (gray_req && gray_addr == LAST_ADDR) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_wr_addr == LAST_ADDR) r_state <= S_DONE;
        end
        S_DONE: begin
          finish <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
